// File: rtl/ttl_pkg.sv
// Shared constants and FSM state type for the TTL-style interrupt priority encoder.
package ttl_pkg;

    localparam int N_LINES = 8;
    localparam int CODE_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVE
    } state_e;

endpackage

// File: rtl/ttl_sync_edge.sv
// Per-line request synchroniser with a registered falling-edge detector.
module ttl_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic req_n_i,
    output logic level_n_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   fall_q;

    // Flops reset to the inactive (high) level so reset itself never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q[0] <= req_n_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            fall_q <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    assign level_n_o = sync_q[SYNC_STAGES-1];
    assign fall_o    = fall_q;

endmodule

// File: rtl/ttl_irq_encoder.sv
// Clocked 74148-style priority encoder with pending capture, masking,
// cascade pins and a CPU irq/ack handshake.
module ttl_irq_encoder
    import ttl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               EI_n,
    input  logic [N_LINES-1:0] I_n,
    input  logic [N_LINES-1:0] mask,
    input  logic               ack,
    output logic [CODE_W-1:0]  A_n,
    output logic               GS_n,
    output logic               EO_n,
    output logic               irq_n,
    output logic [CODE_W-1:0]  vector,
    output logic               vector_valid
);

    logic [N_LINES-1:0] level_n;
    logic [N_LINES-1:0] fall;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] eff;
    logic [N_LINES-1:0] clr;
    logic [CODE_W-1:0]  code;
    logic [CODE_W-1:0]  vector_q, vector_d;
    logic               any;
    state_e             state_q, state_d;

    for (genvar g = 0; g < N_LINES; g++) begin : g_line
        ttl_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk      (clk),
            .reset    (reset),
            .req_n_i  (I_n[g]),
            .level_n_o(level_n[g]),
            .fall_o   (fall[g])
        );
    end

    function automatic logic [CODE_W-1:0] prio_encode(input logic [N_LINES-1:0] v);
        prio_encode = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (v[i]) prio_encode = CODE_W'(i);
        end
    endfunction

    assign eff  = pending_q & ~mask;
    assign any  = |eff;
    assign code = prio_encode(eff);

    assign A_n  = (EI_n || !any) ? {CODE_W{1'b1}} : ~code;
    assign GS_n = EI_n | ~any;
    assign EO_n = EI_n | any;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            vector_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vector_q  <= vector_d;
        end
    end

    // A withdrawn request (mask, level release, cascade disable) drops REQ before ack is honoured.
    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        clr      = '0;
        unique case (state_q)
            IDLE: begin
                if (!EI_n && any) state_d = REQ;
            end
            REQ: begin
                if (EI_n || !any) begin
                    state_d = IDLE;
                end else if (ack) begin
                    vector_d = code;
                    clr      = N_LINES'(1) << code;
                    state_d  = SERVE;
                end
            end
            SERVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pending_d = EDGE_MODE ? ((pending_q & ~clr) | fall) : ~level_n;
    end

    always_comb begin
        irq_n        = (state_q != REQ);
        vector_valid = (state_q == SERVE);
    end

    assign vector = vector_q;

endmodule

// File: tb/tb_ttl_irq_encoder.sv
// Randomised and directed bench for ttl_irq_encoder, edge and level variants side by side.
module tb_ttl_irq_encoder;

    localparam int SS = 2;
    localparam int HD = SS + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       eiN;
    logic [7:0] iN;
    logic [7:0] mask;
    logic       ack;

    logic [2:0] aN  [2];
    logic [2:0] vec [2];
    logic       gsN [2];
    logic       eoN [2];
    logic       irqN[2];
    logic       vv  [2];

    logic [7:0] hist  [HD];
    logic [7:0] mPend [2];
    int         mPhase[2];
    logic [2:0] mVec  [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ttl_irq_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b0)) dutLevel (
        .clk(clk), .reset(reset), .EI_n(eiN), .I_n(iN), .mask(mask), .ack(ack),
        .A_n(aN[0]), .GS_n(gsN[0]), .EO_n(eoN[0]), .irq_n(irqN[0]),
        .vector(vec[0]), .vector_valid(vv[0])
    );

    ttl_irq_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b1)) dutEdge (
        .clk(clk), .reset(reset), .EI_n(eiN), .I_n(iN), .mask(mask), .ack(ack),
        .A_n(aN[1]), .GS_n(gsN[1]), .EO_n(eoN[1]), .irq_n(irqN[1]),
        .vector(vec[1]), .vector_valid(vv[1])
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int topIndex(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Requests reach pending after a fixed sampling delay, so the model keeps a history of sampled inputs.
    task automatic modelEdge();
        logic [7:0] fallNow, eff, clr;
        int c;
        fallNow = hist[SS+1] & ~hist[SS];
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                mPend[m] = 8'h00; mPhase[m] = 0; mVec[m] = 3'd0;
            end else begin
                eff = mPend[m] & ~mask;
                c   = topIndex(eff);
                clr = 8'h00;
                case (mPhase[m])
                    0: if (!eiN && eff != 0) mPhase[m] = 1;
                    1: begin
                        if (eiN || eff == 0) mPhase[m] = 0;
                        else if (ack) begin
                            mVec[m] = c[2:0]; clr = 8'(1) << c; mPhase[m] = 2;
                        end
                    end
                    default: mPhase[m] = 0;
                endcase
                if (m == 1) mPend[m] = (mPend[m] & ~clr) | fallNow;
                else        mPend[m] = ~hist[SS-1];
            end
        end
        for (int k = HD - 1; k > 0; k--) hist[k] = reset ? 8'hFF : hist[k-1];
        hist[0] = reset ? 8'hFF : iN;
    endtask

    task automatic checkAll();
        logic [7:0] eff;
        int expA;
        string nm;
        for (int m = 0; m < 2; m++) begin
            nm   = (m == 1) ? "edge" : "level";
            eff  = mPend[m] & ~mask;
            expA = (eiN || eff == 0) ? 7 : 7 - topIndex(eff);
            checkOutput({nm, " A_n"}, 8'(aN[m]), 8'(expA));
            checkOutput({nm, " GS_n"}, 8'(gsN[m]), 8'(eiN || eff == 0));
            checkOutput({nm, " EO_n"}, 8'(eoN[m]), 8'(eiN || eff != 0));
            checkOutput({nm, " irq_n"}, 8'(irqN[m]), 8'(mPhase[m] != 1));
            checkOutput({nm, " vector_valid"}, 8'(vv[m]), 8'(mPhase[m] == 2));
            checkOutput({nm, " vector"}, 8'(vec[m]), 8'(mVec[m]));
        end
    endtask

    task automatic applyStimulus(input logic [7:0] i, input logic [7:0] m, input logic ei,
                                 input logic a, input logic r);
        iN = i; mask = m; eiN = ei; ack = a; reset = r;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic holdCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(iN, mask, eiN, 1'b0, 1'b0);
    endtask

    task automatic waitReq(input int bound);
        int n = 0;
        while (mPhase[1] != 1 && n < bound) begin
            applyStimulus(iN, mask, eiN, 1'b0, 1'b0);
            n++;
        end
        checkOutput("waitReq edge model", 8'(mPhase[1]), 8'd1);
    endtask

    initial begin
        for (int k = 0; k < HD; k++) hist[k] = 8'hFF;
        for (int m = 0; m < 2; m++) begin
            mPend[m] = 8'h00; mPhase[m] = 0; mVec[m] = 3'd0;
        end
        $display("[TB] starting ttl_irq_encoder bench");

        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        holdCycles(2);

        // Single-cycle pulse on line 5, then acknowledge.
        applyStimulus(8'hDF, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        holdCycles(3);

        // Lines 2 and 6 together: 6 served first, then 2.
        applyStimulus(8'hBB, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hBB, 8'h00, 1'b0, 1'b1, 1'b0);
        waitReq(10);
        applyStimulus(8'hBB, 8'h00, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        holdCycles(4);

        // Mask withdraws line 3 mid-request, unmask restores it.
        applyStimulus(8'hF7, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hFF, 8'h08, 1'b0, 1'b0, 1'b0);
        holdCycles(2);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
        holdCycles(3);

        // Line 1 held low through the acknowledge, then released.
        applyStimulus(8'hFD, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hFD, 8'h00, 1'b0, 1'b1, 1'b0);
        holdCycles(4);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        holdCycles(5);

        // Cascade disable with a pending line, then reset during REQ.
        applyStimulus(8'hEF, 8'h00, 1'b1, 1'b0, 1'b0);
        holdCycles(5);
        applyStimulus(8'hEF, 8'h00, 1'b0, 1'b0, 1'b0);
        waitReq(10);
        applyStimulus(8'hEF, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        holdCycles(4);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] nextI, nextM;
            nextI = iN ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            nextM = ($urandom_range(0, 15) == 0) ? (8'($urandom) & 8'($urandom) & 8'($urandom)) : mask;
            applyStimulus(nextI, nextM, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
